// File: rtl/cipher_block_engine_if.sv
// -----------------------------------------------------------------------------
// cipher_block_engine_if
// Purpose : MCU <-> cipher engine data handshake bundle.
// Signals :
//   read_fifo    MCU -> engine  strobe, rx_data valid this cycle
//   rx_data      MCU -> engine  head word of the receive FIFO
//   key_ready    MCU -> engine  key generation complete
//   is_encrypt   MCU -> engine  1 = encrypt, 0 = decrypt
//   trans_enq    MCU -> engine  strobe, tx_data is enqueued this cycle
//   accepted     engine -> MCU  one-cycle pulse, block taken
//   data_done    engine -> MCU  level, result ready in tx_data
//   tx_data      engine -> MCU  result block
//   busy         engine -> MCU  engine not idle
//   protocol_err engine -> MCU  sticky protocol error flag
// Modports: master (MCU side), slave (engine side).
// -----------------------------------------------------------------------------
interface cipher_block_engine_if #(
   parameter int DATA_W = 64
);
   logic              read_fifo;
   logic [DATA_W-1:0] rx_data;
   logic              key_ready;
   logic              is_encrypt;
   logic              trans_enq;
   logic              accepted;
   logic              data_done;
   logic [DATA_W-1:0] tx_data;
   logic              busy;
   logic              protocol_err;

   modport master (
      output read_fifo, rx_data, key_ready, is_encrypt, trans_enq,
      input  accepted, data_done, tx_data, busy, protocol_err
   );

   modport slave (
      input  read_fifo, rx_data, key_ready, is_encrypt, trans_enq,
      output accepted, data_done, tx_data, busy, protocol_err
   );
endinterface

// File: rtl/cipher_block_engine.sv
// -----------------------------------------------------------------------------
// cipher_block_engine
// Purpose : Takes one block from the receive FIFO, iterates it ROUNDS times
//           through an external combinational round function, then holds the
//           result for the transmit FIFO until the MCU enqueues it.
// Ports   :
//   clk        system clock
//   n_reset    asynchronous active-low reset
//   bus        MCU handshake (cipher_block_engine_if.slave)
//   round_out  result of the external round function
//   round_in   working block fed to the round function
//   round_idx  subkey index of the current round
//   round_en   a round is applied this cycle
// -----------------------------------------------------------------------------
module cipher_block_engine #(
   parameter int DATA_W = 64,
   parameter int ROUNDS = 16,
   parameter int RW     = $clog2(ROUNDS)
) (
   input  logic                   clk,
   input  logic                   n_reset,
   cipher_block_engine_if.slave   bus,
   input  logic [DATA_W-1:0]      round_out,
   output logic [DATA_W-1:0]      round_in,
   output logic [RW-1:0]          round_idx,
   output logic                   round_en
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Final round counter value; also the base for the reversed decrypt index.
   localparam logic [RW-1:0] LAST_CNT = RW'(ROUNDS - 1);

   state_t            state_q,        state_d;
   logic [DATA_W-1:0] blk_q,          blk_d;
   logic [RW-1:0]     cnt_q,          cnt_d;
   logic              mode_q,         mode_d;
   logic              accepted_q,     accepted_d;
   logic              protocol_err_q, protocol_err_d;

   // State and datapath registers, cleared asynchronously so an in-flight
   // block is dropped immediately.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q        <= ST_IDLE;
         blk_q          <= {DATA_W{1'b0}};
         cnt_q          <= {RW{1'b0}};
         mode_q         <= 1'b0;
         accepted_q     <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         blk_q          <= blk_d;
         cnt_q          <= cnt_d;
         mode_q         <= mode_d;
         accepted_q     <= accepted_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   // Next-state logic for the IDLE / RUN / DONE sequence.
   always_comb begin
      state_d        = state_q;
      blk_d          = blk_q;
      cnt_d          = cnt_q;
      mode_d         = mode_q;
      accepted_d     = 1'b0;
      protocol_err_d = protocol_err_q;

      case (state_q)
         ST_IDLE: begin
            // Without a key the request is simply not taken; the MCU retries.
            if (bus.read_fifo && bus.key_ready) begin
               blk_d      = bus.rx_data;
               mode_d     = bus.is_encrypt;
               cnt_d      = {RW{1'b0}};
               accepted_d = 1'b1;
               state_d    = ST_RUN;
            end else begin
               state_d    = ST_IDLE;
            end
            // Nothing is waiting to be enqueued, so the MCU is out of step.
            if (bus.trans_enq) begin
               protocol_err_d = 1'b1;
            end else begin
               protocol_err_d = protocol_err_q;
            end
         end

         ST_RUN: begin
            // Mode and key status are latched at acceptance, so inputs here
            // cannot disturb the round sequence.
            blk_d = round_out;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = {RW{1'b0}};
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + RW'(1);
               state_d = ST_RUN;
            end
            if (bus.trans_enq) begin
               protocol_err_d = 1'b1;
            end else begin
               protocol_err_d = protocol_err_q;
            end
         end

         ST_DONE: begin
            // A read_fifo arriving with trans_enq is not taken; the engine
            // only accepts from IDLE.
            if (bus.trans_enq) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Round index: forward order when encrypting, reversed when decrypting.
   // The subtraction wraps modulo 2^RW by construction.
   always_comb begin
      if (mode_q) begin
         round_idx = cnt_q;
      end else begin
         round_idx = LAST_CNT - cnt_q;
      end
   end

   assign round_in         = blk_q;
   assign round_en         = (state_q == ST_RUN);
   assign bus.tx_data      = blk_q;
   assign bus.accepted     = accepted_q;
   assign bus.data_done    = (state_q == ST_DONE);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.protocol_err = protocol_err_q;

   cipher_block_engine_chk u_chk (
      .clk       (clk),
      .n_reset   (n_reset),
      .accepted  (accepted_q),
      .round_en  (round_en),
      .data_done (bus.data_done),
      .busy      (bus.busy)
   );

endmodule

// -----------------------------------------------------------------------------
// cipher_block_engine_chk
// Purpose : Structural invariants of the engine handshake outputs.
// Ports   : clk, n_reset, and the decoded status outputs of the engine.
// -----------------------------------------------------------------------------
module cipher_block_engine_chk (
   input logic clk,
   input logic n_reset,
   input logic accepted,
   input logic round_en,
   input logic data_done,
   input logic busy
);

   a_accept_in_run : assert property (@(posedge clk) disable iff (!n_reset)
      accepted |-> round_en);

   a_run_done_excl : assert property (@(posedge clk) disable iff (!n_reset)
      !(round_en && data_done));

   a_busy_decode   : assert property (@(posedge clk) disable iff (!n_reset)
      busy == (round_en || data_done));

endmodule

// File: tb/tb_cipher_block_engine.sv
// -----------------------------------------------------------------------------
// tb_cipher_block_engine
// Purpose : Self-checking bench for cipher_block_engine. A behavioural round
//           function drives round_out; expected results are pushed to a
//           scoreboard when a block is offered and popped when data_done
//           is observed.
// -----------------------------------------------------------------------------
module tb_cipher_block_engine;

   localparam int DATA_W = 64;
   localparam int ROUNDS = 16;
   localparam int RW     = 4;

   logic              clk;
   logic              n_reset;
   logic [DATA_W-1:0] round_out;
   logic [DATA_W-1:0] round_in;
   logic [RW-1:0]     round_idx;
   logic              round_en;
   logic              model_xor;

   int                checks_cnt;
   int                errors_cnt;
   logic [DATA_W-1:0] sb_q[$];

   cipher_block_engine_if #(.DATA_W(DATA_W)) bus ();

   cipher_block_engine #(
      .DATA_W (DATA_W),
      .ROUNDS (ROUNDS),
      .RW     (RW)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .bus       (bus),
      .round_out (round_out),
      .round_in  (round_in),
      .round_idx (round_idx),
      .round_en  (round_en)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural round function: increment, optionally mixed with the index.
   assign round_out = model_xor ? ((round_in + 64'd1) ^ {60'd0, round_idx})
                                : (round_in + 64'd1);

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [63:0] din, input logic enc);
      logic [63:0] b;
      logic [3:0]  idx;
      b = din;
      for (int i = 0; i < ROUNDS; i++) begin
         idx = enc ? 4'(i) : 4'(ROUNDS - 1 - i);
         b   = b + 64'd1;
         if (model_xor) b = b ^ {60'd0, idx};
      end
      return b;
   endfunction

   // Offer one block, follow its rounds, hold for 'hold' cycles in DONE,
   // then enqueue. Optional disturbances: toggle is_encrypt mid-run, a
   // read_fifo at T+5, and a read_fifo together with trans_enq.
   task automatic do_block(input logic [63:0] din, input logic enc, input int hold,
                           input bit toggle_mode, input bit poke_rf, input bit rf_with_enq);
      logic [63:0] exp_res;
      bus.rx_data    = din;
      bus.is_encrypt = enc;
      bus.key_ready  = 1'b1;
      bus.trans_enq  = 1'b0;
      bus.read_fifo  = 1'b1;
      sb_q.push_back(model(din, enc));
      tick();
      bus.read_fifo = 1'b0;
      bus.rx_data   = 64'hDEAD_BEEF_0000_0000;
      check("accepted_t1", 64'(bus.accepted), 64'd1);
      for (int r = 0; r < ROUNDS; r++) begin
         check("round_en", 64'(round_en), 64'd1);
         check("round_idx", 64'(round_idx), enc ? 64'(r) : 64'(ROUNDS - 1 - r));
         check("data_done_run", 64'(bus.data_done), 64'd0);
         if (r > 0) check("accepted_run", 64'(bus.accepted), 64'd0);
         if (toggle_mode && r == 3) bus.is_encrypt = ~enc;
         if (poke_rf && r == 4) bus.read_fifo = 1'b1;
         if (r == 5) bus.read_fifo = 1'b0;
         tick();
      end
      check("data_done_rise", 64'(bus.data_done), 64'd1);
      check("round_en_off", 64'(round_en), 64'd0);
      if (sb_q.size() == 0) begin
         check("sb_empty", 64'd0, 64'd1);
         exp_res = 64'd0;
      end else begin
         exp_res = sb_q.pop_front();
         check("tx_data", bus.tx_data, exp_res);
      end
      for (int h = 0; h < hold; h++) begin
         check("hold_done", 64'(bus.data_done), 64'd1);
         check("hold_tx", bus.tx_data, exp_res);
         tick();
      end
      bus.trans_enq = 1'b1;
      if (rf_with_enq) begin
         bus.read_fifo = 1'b1;
         bus.rx_data   = 64'h5555;
      end
      tick();
      bus.trans_enq = 1'b0;
      bus.read_fifo = 1'b0;
      check("done_drop", 64'(bus.data_done), 64'd0);
      check("busy_idle", 64'(bus.busy), 64'd0);
      check("accepted_after_enq", 64'(bus.accepted), 64'd0);
   endtask

   initial begin
      checks_cnt     = 0;
      errors_cnt     = 0;
      model_xor      = 1'b0;
      n_reset        = 1'b0;
      bus.read_fifo  = 1'b0;
      bus.rx_data    = 64'd0;
      bus.key_ready  = 1'b0;
      bus.is_encrypt = 1'b0;
      bus.trans_enq  = 1'b0;
      tick();
      tick();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.data_done), 64'd0);
      check("rst_acc", 64'(bus.accepted), 64'd0);
      check("rst_tx", bus.tx_data, 64'd0);
      check("rst_err", 64'(bus.protocol_err), 64'd0);
      n_reset = 1'b1;
      tick();

      // Encrypt with increment model: 0x10 + 16 rounds = 0x20.
      do_block(64'h10, 1'b1, 3, 1'b0, 1'b0, 1'b0);

      // No key: request not taken.
      bus.key_ready = 1'b0;
      bus.read_fifo = 1'b1;
      bus.rx_data   = 64'h77;
      tick();
      bus.read_fifo = 1'b0;
      check("nokey_acc", 64'(bus.accepted), 64'd0);
      check("nokey_busy", 64'(bus.busy), 64'd0);
      tick();

      // read_fifo during RUN is ignored; result still 0x20.
      do_block(64'h10, 1'b1, 3, 1'b0, 1'b1, 1'b0);

      // Decrypt with xor model, mode toggled mid-run.
      model_xor = 1'b1;
      do_block(64'h0123_4567_89AB_CDEF, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      do_block({$urandom, $urandom}, 1'b1, 2, 1'b1, 1'b0, 1'b0);

      // Long hold, then read_fifo alongside trans_enq.
      do_block(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 50, 1'b0, 1'b0, 1'b1);

      // Protocol error: trans_enq in IDLE, sticky through a later block.
      bus.trans_enq = 1'b1;
      tick();
      bus.trans_enq = 1'b0;
      check("perr_set", 64'(bus.protocol_err), 64'd1);
      check("perr_busy", 64'(bus.busy), 64'd0);
      do_block(64'h42, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      check("perr_sticky", 64'(bus.protocol_err), 64'd1);

      // Reset at RUN cycle 7 (block not scoreboarded: it is discarded).
      bus.rx_data    = 64'h99;
      bus.is_encrypt = 1'b1;
      bus.key_ready  = 1'b1;
      bus.read_fifo  = 1'b1;
      tick();
      bus.read_fifo = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("mid_run_en", 64'(round_en), 64'd1);
      n_reset = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_en", 64'(round_en), 64'd0);
      check("arst_done", 64'(bus.data_done), 64'd0);
      check("arst_acc", 64'(bus.accepted), 64'd0);
      check("arst_tx", bus.tx_data, 64'd0);
      check("arst_rin", round_in, 64'd0);
      check("arst_err", 64'(bus.protocol_err), 64'd0);
      tick();
      n_reset = 1'b1;
      tick();
      do_block(64'h1234, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("post_rst_err", 64'(bus.protocol_err), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/cipher_block_engine.md
Name: cipher_block_engine

Overview:
- Responder to the MCU data handshake. It takes one DATA_W-bit block from the receive FIFO and runs ROUNDS iterations through an external combinational round-function datapath.
- When the rounds finish, it holds the result for the transmit FIFO until the MCU enqueues it.
- It drives the `accepted` and `data_done` signals that the MCU consumes, and it responds to the MCU's `read_fifo` and `trans_enq` strobes.

Parameters:
- DATA_W, 64, block width in bits.
- ROUNDS, 16, rounds per block; must be at least 2.
- RW, $clog2(ROUNDS), width of the round index and round counter.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous reset, active-low.
- read_fifo  input  1  MCU strobe; rx_data is valid in the same cycle.
- rx_data  input  DATA_W  head word of the receive FIFO.
- key_ready  input  1  key generation complete (MCU status bit 3).
- is_encrypt  input  1  mode: 1 = encrypt, 0 = decrypt.
- trans_enq  input  1  MCU strobe; tx_data is written into the transmit FIFO this cycle.
- round_out  input  DATA_W  result of the external round function for round_in/round_idx.
- accepted  output  1  one-cycle pulse: block taken.
- data_done  output  1  level: result ready in tx_data.
- tx_data  output  DATA_W  result block.
- round_in  output  DATA_W  current working block, fed to the round function.
- round_idx  output  RW  subkey index for the current round.
- round_en  output  1  a round is being applied this cycle.
- busy  output  1  engine is not in IDLE.
- protocol_err  output  1  sticky error flag.

Behaviour:
- States are IDLE, RUN and DONE.
- Registers are state, blk[DATA_W], cnt[RW], mode, accepted and protocol_err.
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE; blk, cnt, mode, accepted and protocol_err all 0.
  - All outputs 0, except round_idx, which follows its formula and is don't-care.
  - Any block in flight is discarded.
- Output mapping:
  - round_in = blk.
  - tx_data = blk.
  - busy = (state != IDLE).
  - data_done = (state == DONE).
  - round_en = (state == RUN).
- round_idx:
  - mode=1: round_idx = cnt.
  - mode=0: round_idx = ROUNDS-1-cnt, taken modulo 2^RW.
- IDLE behaviour:
  - If read_fifo and key_ready: blk<=rx_data, mode<=is_encrypt, cnt<=0, accepted<=1, state<=RUN.
  - If read_fifo and !key_ready: accepted stays 0 and state stays IDLE. The MCU will retry.
- RUN behaviour:
  - Every cycle: blk<=round_out and cnt<=cnt+1.
  - When cnt==ROUNDS-1: cnt<=0 and state<=DONE.
  - key_ready and is_encrypt are ignored while in RUN.
- DONE behaviour:
  - blk is held stable.
  - On trans_enq: state<=IDLE.
- accepted:
  - Registered pulse, high only in the cycle after an accepted read_fifo. That cycle is also the first RUN cycle.
  - read_fifo seen in RUN or DONE gives accepted=0 next cycle; state and blk are unaffected.
- Latency:
  - read_fifo in cycle T gives accepted in T+1.
  - Rounds run in cycles T+1 through T+ROUNDS.
  - data_done is high from T+ROUNDS+1 until the cycle after trans_enq.
- data_done is a level, not a pulse. The MCU only samples it in its IDLE state, so it must stay high until trans_enq.
- trans_enq and read_fifo in the same DONE cycle: trans_enq is honoured and read_fifo is rejected (accepted=0).
- trans_enq seen in IDLE or RUN: ignored for state; protocol_err<=1. protocol_err is cleared only by reset.
- The engine holds one block at a time; there is no internal queueing.

Test Plan:
- Encrypt, ROUNDS=16, bench model round_out=round_in+1:
  - Stimulus: key_ready=1, is_encrypt=1, read_fifo pulse with rx_data=64'h10 at T.
  - Required: accepted=1 only at T+1; round_en at T+1..T+16 with round_idx 0,1,...,15; data_done rises at T+17 with tx_data=64'h20.
  - trans_enq at T+20 drops data_done at T+21 and busy=0.
- Decrypt, same model plus round_out=round_in ^ round_idx:
  - Stimulus: is_encrypt=0.
  - Required: round_idx sequence is 15,14,...,0.
  - is_encrypt toggled mid-RUN leaves the sequence unchanged.
- Reject cases:
  - read_fifo while key_ready=0 -> accepted=0, busy=0.
  - read_fifo at cycle T+5 of a RUN -> accepted=0 at T+6; the final tx_data is unchanged (64'h20).
- Hold-until-dequeue:
  - Stimulus: delay trans_enq by 50 cycles after data_done rises.
  - Required: data_done and tx_data stay stable for the whole delay; a read_fifo in the same cycle as trans_enq gets accepted=0.
- Protocol error:
  - Stimulus: trans_enq pulse in IDLE.
  - Required: protocol_err=1 next cycle and it stays 1 through later normal blocks; n_reset low clears it.
- Reset mid-operation:
  - Stimulus: n_reset asserted at RUN cycle 7.
  - Required: state IDLE and all outputs 0 immediately (asynchronous); after release, a fresh block completes correctly in 16 rounds.
